bus_controller: RTL and testbench
=================================

# bus_controller

Sequencing and arbitration controller for the two-master / three-slave bus datapath. It arbitrates round-robin between two masters and drives the datapath's register loads (`sel1`..`sel4`), its mux selects (`mux1`, `mux2`) and its tri-state enables (`Aout`, `Dout`). It then runs each granted transfer through address, write-data and transfer phases. Completion and error status come back to the granted master from the datapath's read-mux outputs `rdyout` / `respout`.

## Interface
- `TIMEOUT_CYCLES`, default 15: number of XFER wait cycles with `rdyout`=0 before abort. Used only when `BUS_TIMEOUT_EN` is defined. Must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req1`, `req2` in 1 each: master transfer request, level. Held until the master's `done`.
- `write1`, `write2` in 1 each: 1 = write, 0 = read. Sampled with the grant in IDLE.
- `rdyout` in 1: slave ready from the datapath read mux.
- `respout` in 2: slave response. 2'b00 = OKAY, 2'b01 = ERROR, others treated as OKAY.
- `sel1`, `sel2` out 1 each: load enables for the address registers of master 1 and master 2.
- `sel3`, `sel4` out 1 each: load enables for the write-data registers of master 1 and master 2.
- `mux1`, `mux2` out 1 each: address and data mux selects. 0 = master 1, 1 = master 2.
- `Aout`, `Dout` out 1 each: address and write-data tri-state enables.
- `gnt1`, `gnt2` out 1 each: grant, high from ADDR through DONE.
- `done1`, `done2` out 1 each: one-cycle completion pulse.
- `err1`, `err2` out 1 each: valid with `done`. 1 = ERROR response or timeout.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ADDR, WDATA, XFER, DONE.
- All outputs are decoded from registered state plus registered `owner` and `wr`. There is no combinational input-to-output path.
- **IDLE**: all outputs 0.
  - If any request is pending, latch `owner` and `wr`, then go to ADDR.
  - Arbitration: if only one request is high, that master wins. If both are high, the master not granted last wins.
  - `last` pointer resets to master 2, so master 1 wins the first tie.
- **ADDR**: `sel1` (owner 1) or `sel2` (owner 2) is 1; the address register captures `Abus` at the end of this cycle. `mux1`=`owner`; `gnt` is 1.
  - Next state: WDATA if `wr`, else XFER.
- **WDATA**: `sel3` (owner 1) or `sel4` (owner 2) is 1. `mux2`=`owner`, `mux1` held, `Aout`=1.
  - Next state: XFER.
- **XFER**: `Aout`=1, `Dout`=`wr`, both mux selects held.
  - If `rdyout`=1: capture `err` = (`respout`==2'b01), then go to DONE.
  - Otherwise stay in XFER (wait state).
- **DONE**: the owner's `done`=1 and `err`=registered value, with `gnt` still 1. `last` is updated to `owner`.
  - Next state: always IDLE.
- A master must hold `Abus`, `bus_dout`, `req` and `write` stable while granted. It drops `req` on the edge that ends DONE.
  - If `req` is still high in IDLE, it is treated as a new transfer.
- The non-owner's request is ignored until IDLE.
- `rst` asserted at any time immediately forces IDLE, `last`=master 2, wait counter 0, and all outputs 0. An in-flight transfer is dropped without a `done`.

## Timing
- Request seen high at edge k:
  - Read: ADDR in cycle k+1, XFER in k+2, DONE in k+3 with a zero-wait slave.
  - Write: one cycle more (DONE in k+4).
- Each slave wait cycle adds one cycle.
- At least one IDLE cycle separates back-to-back transfers.
- `sel*` is a single-cycle pulse per transfer.
- `Aout` is high from WDATA or XFER entry until DONE entry.

## Configuration
- Macro: `BUS_TIMEOUT_EN`.
- **Defined**:
  - A wait counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on XFER entry and increments on each XFER cycle with `rdyout`=0.
  - When it reaches `TIMEOUT_CYCLES` with `rdyout` still 0, the FSM goes to DONE with `err`=1.
  - If `rdyout`=1 arrives on that same cycle, it wins: the normal response is taken.
- **Undefined**: no counter logic; XFER waits indefinitely.

## Test plan
- **Single read**: `req1`=1, `write1`=0, `rdyout`=1, `respout`=00 -> `sel1` at k+1, XFER at k+2, `done1`=1 and `err1`=0 at k+3; `sel3`/`Dout` never 1.
- **Write**: `req2`=1, `write2`=1 -> `sel2`+`mux1`=1 at k+1, `sel4`+`mux2`=1 at k+2, `Dout`=1 at k+3, `done2` at k+4.
- **Tie round-robin**: `req1`=`req2`=1 held continuously from reset -> grants alternate 1, 2, 1, 2; no double grant.
- **Wait states and error**: `rdyout`=0 for 3 XFER cycles, then 1 with `respout`=01 -> XFER lasts 4 cycles; `done1`=1 with `err1`=1.
- **Timeout** (`BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): `rdyout` stuck 0 -> DONE after 4 XFER cycles with `err`=1. Without the macro, still in XFER after 100 cycles.
- **Reset mid-XFER**: assert `rst` asynchronously -> all outputs 0 before the next edge; no `done`; after release, master 1 wins a tie.

Source files
------------

// File: rtl/bus_controller_if.sv
// Handshake, slave-status and datapath-control bundle for bus_controller.
// master: the controller's view; slave: the masters/datapath side driving requests and status.
interface bus_controller_if;
  logic       req1, req2;
  logic       write1, write2;
  logic       rdyout;
  logic [1:0] respout;
  logic       sel1, sel2, sel3, sel4;
  logic       mux1, mux2;
  logic       Aout, Dout;
  logic       gnt1, gnt2;
  logic       done1, done2;
  logic       err1, err2;
  logic       busy;

  modport master (
    input  req1, req2, write1, write2, rdyout, respout,
    output sel1, sel2, sel3, sel4, mux1, mux2, Aout, Dout,
           gnt1, gnt2, done1, done2, err1, err2, busy
  );

  modport slave (
    output req1, req2, write1, write2, rdyout, respout,
    input  sel1, sel2, sel3, sel4, mux1, mux2, Aout, Dout,
           gnt1, gnt2, done1, done2, err1, err2, busy
  );
endinterface

// File: rtl/bus_controller.sv
// Round-robin two-master sequencer: ADDR -> [WDATA] -> XFER -> DONE per granted transfer.
// Optional XFER timeout is enabled by defining BUS_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module bus_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst,
  bus_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    XFER  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  // owner/last: 0 = master 1, 1 = master 2
  logic   owner_q, owner_d;
  logic   wr_q, wr_d;
  logic   err_q, err_d;
  logic   last_q, last_d;
  logic   win;
  logic   timeout_c;

  logic sel1_d, sel2_d, sel3_d, sel4_d;
  logic mux1_d, mux2_d, aout_d, dout_d;
  logic gnt1_d, gnt2_d, done1_d, done2_d, err1_d, err2_d, busy_d;

  // TIMEOUT_CYCLES must be >= 1; a zero value leaves this guard block as the only trace.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Wait counter is zero outside XFER, so it is clear on every XFER entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= '0;
    else if (state_q != XFER)   wait_cnt <= '0;
    else if (!bus.rdyout)       wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_c = (state_q == XFER) && !bus.rdyout &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b1;
      bus.sel1  <= 1'b0;
      bus.sel2  <= 1'b0;
      bus.sel3  <= 1'b0;
      bus.sel4  <= 1'b0;
      bus.mux1  <= 1'b0;
      bus.mux2  <= 1'b0;
      bus.Aout  <= 1'b0;
      bus.Dout  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.gnt2  <= 1'b0;
      bus.done1 <= 1'b0;
      bus.done2 <= 1'b0;
      bus.err1  <= 1'b0;
      bus.err2  <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      last_q    <= last_d;
      bus.sel1  <= sel1_d;
      bus.sel2  <= sel2_d;
      bus.sel3  <= sel3_d;
      bus.sel4  <= sel4_d;
      bus.mux1  <= mux1_d;
      bus.mux2  <= mux2_d;
      bus.Aout  <= aout_d;
      bus.Dout  <= dout_d;
      bus.gnt1  <= gnt1_d;
      bus.gnt2  <= gnt2_d;
      bus.done1 <= done1_d;
      bus.done2 <= done2_d;
      bus.err1  <= err1_d;
      bus.err2  <= err2_d;
      bus.busy  <= busy_d;
    end
  end

  // Next-state, arbitration and per-transfer context.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    err_d   = err_q;
    last_d  = last_q;
    win     = (bus.req1 && bus.req2) ? !last_q : bus.req2;
    unique case (state_q)
      IDLE: begin
        if (bus.req1 || bus.req2) begin
          owner_d = win;
          wr_d    = win ? bus.write2 : bus.write1;
          err_d   = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR:  state_d = wr_q ? WDATA : XFER;
      WDATA: state_d = XFER;
      XFER: begin
        if (bus.rdyout) begin
          err_d   = (bus.respout == 2'b01);
          state_d = DONE;
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    sel1_d  = 1'b0;
    sel2_d  = 1'b0;
    sel3_d  = 1'b0;
    sel4_d  = 1'b0;
    mux1_d  = 1'b0;
    mux2_d  = 1'b0;
    aout_d  = 1'b0;
    dout_d  = 1'b0;
    done1_d = 1'b0;
    done2_d = 1'b0;
    err1_d  = 1'b0;
    err2_d  = 1'b0;
    unique case (state_d)
      ADDR: begin
        sel1_d = !owner_d;
        sel2_d = owner_d;
        mux1_d = owner_d;
      end
      WDATA: begin
        sel3_d = !owner_d;
        sel4_d = owner_d;
        mux1_d = owner_d;
        mux2_d = owner_d;
        aout_d = 1'b1;
      end
      XFER: begin
        mux1_d = owner_d;
        mux2_d = owner_d && wr_d;
        aout_d = 1'b1;
        dout_d = wr_d;
      end
      DONE: begin
        done1_d = !owner_d;
        done2_d = owner_d;
        err1_d  = !owner_d && err_d;
        err2_d  = owner_d && err_d;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    gnt1_d = busy_d && !owner_d;
    gnt2_d = busy_d && owner_d;
  end

endmodule

// File: tb/tb_bus_controller.sv
// Directed bench for bus_controller with a cycle-level transfer model checked every cycle.
module tb_bus_controller;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;

  bus_controller_if bus_if ();
  bus_controller #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // {sel1,sel2,sel3,sel4,mux1,mux2,Aout,Dout,gnt1,gnt2,done1,done2,err1,err2,busy}
  function automatic logic [14:0] dut_vec();
    return {bus_if.sel1, bus_if.sel2, bus_if.sel3, bus_if.sel4, bus_if.mux1, bus_if.mux2,
            bus_if.Aout, bus_if.Dout, bus_if.gnt1, bus_if.gnt2, bus_if.done1, bus_if.done2,
            bus_if.err1, bus_if.err2, bus_if.busy};
  endfunction

  // Transfer model: active transfer, owner (0=m1,1=m2), cycles since grant, finished flag.
  bit m_act = 1'b0, m_own = 1'b0, m_wr = 1'b0, m_fin = 1'b0, m_err = 1'b0, m_last = 1'b1;
  int m_n = 0, m_wait = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0; m_fin = 1'b0; m_last = 1'b1; m_wait = 0;
    end else if (!m_act) begin
      if (bus_if.req1 || bus_if.req2) begin
        m_own  = (bus_if.req1 && bus_if.req2) ? !m_last : bus_if.req2;
        m_wr   = m_own ? bus_if.write2 : bus_if.write1;
        m_act  = 1'b1; m_n = 0; m_fin = 1'b0; m_err = 1'b0; m_wait = 0;
      end
    end else if (m_fin) begin
      m_last = m_own; m_act = 1'b0; m_fin = 1'b0;
    end else begin
      if (m_n >= (m_wr ? 2 : 1)) begin
        if (bus_if.rdyout) begin
          m_fin = 1'b1; m_err = (bus_if.respout == 2'b01);
        end else begin
          m_wait++;
`ifdef BUS_TIMEOUT_EN
          if (m_wait == int'(TO)) begin m_fin = 1'b1; m_err = 1'b1; end
`endif
        end
      end
      m_n++;
    end
  end

  function automatic logic [14:0] exp_vec();
    logic [14:0] v;
    v = '0;
    if (m_act) begin
      v[0] = 1'b1;
      v[6] = !m_own;
      v[5] = m_own;
      if (m_fin) begin
        v[4] = !m_own; v[3] = m_own; v[2] = !m_own && m_err; v[1] = m_own && m_err;
      end else if (m_n == 0) begin
        v[14] = !m_own; v[13] = m_own; v[10] = m_own;
      end else if (m_n == 1 && m_wr) begin
        v[12] = !m_own; v[11] = m_own; v[10] = m_own; v[9] = m_own; v[8] = 1'b1;
      end else begin
        v[10] = m_own; v[9] = m_own && m_wr; v[8] = 1'b1; v[7] = m_wr;
      end
    end
    return v;
  endfunction

  // Per-cycle compare; mux selects are don't-care during DONE.
  always @(negedge clk) begin
    logic [14:0] msk;
    if (cmp_en) begin
      msk = (m_act && m_fin) ? 15'h79FF : 15'h7FFF;
      chk("cycle_outputs", 32'(dut_vec() & msk), 32'(exp_vec() & msk));
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  int g[$];

  initial begin
    rst = 1'b1;
    bus_if.req1 = 1'b0; bus_if.req2 = 1'b0; bus_if.write1 = 1'b0; bus_if.write2 = 1'b0;
    bus_if.rdyout = 1'b0; bus_if.respout = 2'b00;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", 32'(dut_vec()), 32'h0);
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // single read, master 1, zero-wait slave
    bus_if.req1 = 1'b1; bus_if.write1 = 1'b0; bus_if.rdyout = 1'b1; bus_if.respout = 2'b00;
    @(negedge clk); chk("rd_addr", {bus_if.sel1, bus_if.sel2, bus_if.mux1, bus_if.gnt1, bus_if.busy}, 5'b10011);
    @(negedge clk); chk("rd_xfer", {bus_if.Aout, bus_if.Dout, bus_if.sel3, bus_if.gnt1}, 4'b1001);
    @(negedge clk); chk("rd_done", {bus_if.done1, bus_if.err1, bus_if.gnt1}, 3'b101);
    bus_if.req1 = 1'b0;
    @(negedge clk); chk("rd_idle", 32'(bus_if.busy), 32'h0);

    // write, master 2
    bus_if.req2 = 1'b1; bus_if.write2 = 1'b1;
    @(negedge clk); chk("wr_addr", {bus_if.sel2, bus_if.sel1, bus_if.mux1, bus_if.gnt2}, 4'b1011);
    @(negedge clk); chk("wr_wdata", {bus_if.sel4, bus_if.mux2, bus_if.mux1, bus_if.Aout, bus_if.Dout}, 5'b11110);
    @(negedge clk); chk("wr_xfer", {bus_if.Dout, bus_if.Aout, bus_if.sel4}, 3'b110);
    @(negedge clk); chk("wr_done", {bus_if.done2, bus_if.err2}, 2'b10);
    bus_if.req2 = 1'b0; bus_if.write2 = 1'b0;
    @(negedge clk);

    // three wait states then ERROR response
    bus_if.req1 = 1'b1; bus_if.rdyout = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); chk("wait_xfer", {bus_if.Aout, bus_if.done1, bus_if.gnt1}, 3'b101);
      if (i == 4) begin bus_if.rdyout = 1'b1; bus_if.respout = 2'b01; end
    end
    @(negedge clk); chk("wait_done", {bus_if.done1, bus_if.err1}, 2'b11);
    bus_if.req1 = 1'b0; bus_if.respout = 2'b00;
    @(negedge clk);

    // tie held from reset: grants alternate
    bus_if.req1 = 1'b1; bus_if.req2 = 1'b1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus_if.sel1) g.push_back(1);
      if (bus_if.sel2) g.push_back(2);
    end
    bus_if.req1 = 1'b0; bus_if.req2 = 1'b0;
    @(negedge clk);
    chk("rr_count", 32'(g.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(g[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // reset mid-XFER restores the last pointer: m1 last, then m2 in flight
    bus_if.req1 = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.req1 = 1'b0;
    @(negedge clk);
    bus_if.req2 = 1'b1; bus_if.rdyout = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1; bus_if.req1 = 1'b1;
    #2 chk("rst_async", 32'(dut_vec()), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0; bus_if.rdyout = 1'b1;
    @(negedge clk); chk("rst_tie", {bus_if.sel1, bus_if.sel2, bus_if.gnt1}, 3'b101);
    @(negedge clk);
    @(negedge clk); chk("rst_tie_done", 32'(bus_if.done1), 32'h1);
    bus_if.req1 = 1'b0; bus_if.req2 = 1'b0;
    @(negedge clk);

    // stuck slave
    bus_if.req1 = 1'b1; bus_if.rdyout = 1'b0;
    @(negedge clk);
`ifdef BUS_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); chk("to_xfer", {bus_if.Aout, bus_if.done1}, 2'b10);
    end
    @(negedge clk); chk("to_done", {bus_if.done1, bus_if.err1}, 2'b11);
    bus_if.req1 = 1'b0;
    @(negedge clk);
`else
    repeat (100) @(negedge clk);
    chk("no_timeout", {bus_if.busy, bus_if.gnt1, bus_if.Aout, bus_if.done1}, 4'b1110);
    bus_if.req1 = 1'b0;
    do_reset();
`endif
    bus_if.rdyout = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
